// File: rtl/alu_if.sv
// alu_if: operand/command bus between the ALU bench (master) and alu_core (slave).
interface alu_if #(
    parameter int WIDTH = 8,
    parameter int CMD_WIDTH = 4
);
    logic ce, mode, cin;
    logic [CMD_WIDTH-1:0] cmd;
    logic [1:0] inp_valid;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH:0] res;
    logic cout, oflow, err, g, l, e;
    modport master(output ce, mode, cmd, inp_valid, opa, opb, cin,
                   input res, cout, oflow, err, g, l, e);
    modport slave(input ce, mode, cmd, inp_valid, opa, opb, cin,
                  output res, cout, oflow, err, g, l, e);
endinterface

// File: rtl/alu_core.sv
// alu_core: registered ALU that gathers split operands and times out partial ops.
module alu_core #(
    parameter int WIDTH = 8,
    parameter int CMD_WIDTH = 4,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    alu_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int OW = WIDTH + 7;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [OW-1:0] ERR = OW'(8);
    typedef enum logic {IDLE, WAIT} state_e;
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, a, b;
    logic ha_q, ha_d, hb_q, hb_d, mode_q, mode_d, m;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_d, c;
    logic [OW-1:0] out_q, out_d, o;
    logic [WIDTH:0] xa, xb, ci, r;
    logic [2*WIDTH-1:0] rl, rr;
    logic co, ov, er, gt, lt, eq;
    logic [1:0] nd;

    // {needs B, needs A}; unknown codes need nothing so they report err at once
    function automatic logic [1:0] need_f(input logic md, input logic [CMD_WIDTH-1:0] cd);
        int k;
        k = int'(cd);
        if (md) return (k <= 3 || k == 8) ? 2'b11 : k <= 5 ? 2'b01 : k <= 7 ? 2'b10 : 2'b00;
        return (k <= 5 || k == 12 || k == 13) ? 2'b11 :
               (k == 6 || k == 8 || k == 9) ? 2'b01 :
               (k == 7 || k == 10 || k == 11) ? 2'b10 : 2'b00;
    endfunction

    always_comb begin
        m = state_q == WAIT ? mode_q : bus.mode;
        c = state_q == WAIT ? cmd_q : bus.cmd;
        a = bus.inp_valid[0] ? bus.opa : a_q;
        b = bus.inp_valid[1] ? bus.opb : b_q;
        xa = {1'b0, a};
        xb = {1'b0, b};
        ci = {{WIDTH{1'b0}}, bus.cin};
        rl = {a, a} << b[SW-1:0];
        rr = {a, a} >> b[SW-1:0];
        r = '0;
        co = 1'b0;
        ov = 1'b0;
        er = 1'b0;
        gt = 1'b0;
        lt = 1'b0;
        eq = 1'b0;
        if (m) begin
            case (int'(c))
                0: begin r = xa + xb; co = r[WIDTH]; end
                1: begin r = xa - xb; ov = xa < xb; end
                2: begin r = xa + xb + ci; co = r[WIDTH]; end
                3: begin r = xa - xb - ci; ov = xa < xb + ci; end
                4: begin r = {1'b0, a + ONE}; ov = a == '1; end
                5: begin r = {1'b0, a - ONE}; ov = a == '0; end
                6: begin r = {1'b0, b + ONE}; ov = b == '1; end
                7: begin r = {1'b0, b - ONE}; ov = b == '0; end
                8: begin gt = a > b; lt = a < b; eq = a == b; end
                default: er = 1'b1;
            endcase
        end else begin
            case (int'(c))
                0: r = {1'b0, a & b};
                1: r = {1'b0, ~(a & b)};
                2: r = {1'b0, a | b};
                3: r = {1'b0, ~(a | b)};
                4: r = {1'b0, a ^ b};
                5: r = {1'b0, ~(a ^ b)};
                6: r = {1'b0, ~a};
                7: r = {1'b0, ~b};
                8: r = {1'b0, a >> 1};
                9: r = {1'b0, a << 1};
                10: r = {1'b0, b >> 1};
                11: r = {1'b0, b << 1};
                12: begin r = {1'b0, rl[2*WIDTH-1:WIDTH]}; er = |b[WIDTH-1:SW]; end
                13: begin r = {1'b0, rr[WIDTH-1:0]}; er = |b[WIDTH-1:SW]; end
                default: er = 1'b1;
            endcase
        end
        o = {r, co, ov, er, gt, lt, eq};
    end

    always_comb begin
        nd = need_f(m, c);
        state_d = state_q;
        cnt_d = cnt_q;
        out_d = out_q;
        a_d = a_q;
        b_d = b_q;
        ha_d = ha_q;
        hb_d = hb_q;
        mode_d = mode_q;
        cmd_d = cmd_q;
        if (bus.ce) begin
            a_d = a;
            b_d = b;
            ha_d = (state_q == WAIT && ha_q) || bus.inp_valid[0];
            hb_d = (state_q == WAIT && hb_q) || bus.inp_valid[1];
            if (state_q == IDLE) begin
                mode_d = bus.mode;
                cmd_d = bus.cmd;
                cnt_d = CW'(1);
                if ((nd & ~bus.inp_valid) == 2'b00) out_d = o;
                else if ((nd & bus.inp_valid) != 2'b00) state_d = WAIT;
            end else if (ha_d && hb_d) begin
                out_d = o;
                state_d = IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                out_d = ERR;
                state_d = IDLE;
            end else cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            out_q <= '0;
            a_q <= '0;
            b_q <= '0;
            ha_q <= 1'b0;
            hb_q <= 1'b0;
            mode_q <= 1'b0;
            cmd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            a_q <= a_d;
            b_q <= b_d;
            ha_q <= ha_d;
            hb_q <= hb_d;
            mode_q <= mode_d;
            cmd_q <= cmd_d;
        end
    end

    assign bus.res = out_q[OW-1:6];
    assign bus.cout = out_q[5];
    assign bus.oflow = out_q[4];
    assign bus.err = out_q[3];
    assign bus.g = out_q[2];
    assign bus.l = out_q[1];
    assign bus.e = out_q[0];
endmodule
